hdmi_period_decoder: RTL and testbench

HDMI_PERIOD_DECODER -- requirements
Module: hdmi_period_decoder

---
 rtl/hdmi_period_decoder_if.sv | 42 ++++
 rtl/hdmi_period_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_hdmi_period_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hdmi_period_decoder_if.sv
// Decoder-side bundle: raw deserialised TMDS words in, decoded period/sideband/error status out.
// master = word source and status consumer, slave = decoder.
interface hdmi_period_decoder_if #(
  parameter int ERR_CNT_W = 16
);
  logic [29:0]          deser_data;
  logic                 clr_err_in;
  logic                 hsync_terc4;
  logic                 vsync_terc4;
  logic [11:0]          island_data;
  logic                 island_valid;
  logic                 video_active;
  logic [2:0]           period_state;
  logic                 terc4_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output deser_data,
    output clr_err_in,
    input  hsync_terc4,
    input  vsync_terc4,
    input  island_data,
    input  island_valid,
    input  video_active,
    input  period_state,
    input  terc4_err,
    input  err_count
  );

  modport slave (
    input  deser_data,
    input  clr_err_in,
    output hsync_terc4,
    output vsync_terc4,
    output island_data,
    output island_valid,
    output video_active,
    output period_state,
    output terc4_err,
    output err_count
  );
endinterface

// File: rtl/hdmi_period_decoder.sv
// HDMI period tracker: finds preambles/guard bands, decodes control and TERC4 words, counts TERC4 errors.
// All outputs registered, 1 cycle after deser_data; one word per clk_1x_in, no backpressure.
module hdmi_period_decoder #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk_1x_in,
  input  logic                 rst_n_in,
  hdmi_period_decoder_if.slave bus
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int GW = $clog2(GUARD_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
  localparam logic [GW-1:0] GB_MAX  = GW'(GUARD_LEN);

  localparam logic [9:0] GB_VID_OUTER = 10'b1011001100;
  localparam logic [9:0] GB_MID       = 10'b0100110011;

  typedef enum logic [2:0] {
    ST_CTRL        = 3'd0,
    ST_VID_GB      = 3'd1,
    ST_VIDEO       = 3'd2,
    ST_DI_GB_LEAD  = 3'd3,
    ST_ISLAND      = 3'd4,
    ST_DI_GB_TRAIL = 3'd5
  } state_t;

  // Returns {valid, c1, c0}.
  function automatic logic [2:0] ctrl_dec(input logic [9:0] w);
    logic [2:0] r;
    r = 3'b000;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  // Returns {valid, nibble}.
  function automatic logic [4:0] terc4_dec(input logic [9:0] w);
    logic [4:0] r;
    r = 5'h00;
    case (w)
      10'b1010011100: r = 5'h10;
      10'b1001100011: r = 5'h11;
      10'b1011100100: r = 5'h12;
      10'b1011100010: r = 5'h13;
      10'b0101110001: r = 5'h14;
      10'b0100011110: r = 5'h15;
      10'b0110001110: r = 5'h16;
      10'b0100111100: r = 5'h17;
      10'b1011001100: r = 5'h18;
      10'b0100111001: r = 5'h19;
      10'b0110011100: r = 5'h1A;
      10'b1011000110: r = 5'h1B;
      10'b1010001110: r = 5'h1C;
      10'b1001110001: r = 5'h1D;
      10'b0101100011: r = 5'h1E;
      10'b1011000011: r = 5'h1F;
      default:        r = 5'h00;
    endcase
    return r;
  endfunction

  logic [9:0] ch0, ch1, ch2;
  logic [2:0] c0d, c1d, c2d;
  logic [4:0] t0d, t1d, t2d;
  logic       is_pre, vid_gb, isl_gb;

  assign ch0 = bus.deser_data[9:0];
  assign ch1 = bus.deser_data[19:10];
  assign ch2 = bus.deser_data[29:20];

  assign c0d = ctrl_dec(ch0);
  assign c1d = ctrl_dec(ch1);
  assign c2d = ctrl_dec(ch2);
  assign t0d = terc4_dec(ch0);
  assign t1d = terc4_dec(ch1);
  assign t2d = terc4_dec(ch2);

  assign is_pre = (c1d == 3'b101) && c2d[2];
  assign vid_gb = (ch0 == GB_VID_OUTER) && (ch1 == GB_MID) && (ch2 == GB_VID_OUTER);
  assign isl_gb = (ch1 == GB_MID) && (ch2 == GB_MID) && t0d[4];

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [1:0]      pre_pat_q, pre_pat_d;
  logic [GW-1:0]   gb_cnt_q, gb_cnt_d;
  logic            isl_ctrl_err;

  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_CTRL;
      pre_cnt_q <= '0;
      pre_pat_q <= '0;
      gb_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      pre_pat_q <= pre_pat_d;
      gb_cnt_q  <= gb_cnt_d;
    end
  end

  // Guard states hand over on the word after the last guard word, so that word
  // is already classified as VIDEO/ISLAND payload.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = '0;
    pre_pat_d    = pre_pat_q;
    gb_cnt_d     = '0;
    isl_ctrl_err = 1'b0;
    case (state_q)
      ST_CTRL: begin
        if (is_pre) begin
          pre_pat_d = c2d[1:0];
          if ((pre_cnt_q != '0) && (c2d[1:0] == pre_pat_q))
            pre_cnt_d = (pre_cnt_q == PRE_MAX) ? PRE_MAX : pre_cnt_q + 1'b1;
          else
            pre_cnt_d = PW'(1);
        end else if ((pre_cnt_q == PRE_MAX) && (pre_pat_q == 2'b00) && vid_gb) begin
          state_d  = ST_VID_GB;
          gb_cnt_d = GW'(1);
        end else if ((pre_cnt_q == PRE_MAX) && (pre_pat_q == 2'b01) && isl_gb) begin
          state_d  = ST_DI_GB_LEAD;
          gb_cnt_d = GW'(1);
        end
      end
      ST_VID_GB: begin
        if (gb_cnt_q == GB_MAX) begin
          state_d = ST_VIDEO;
        end else if (vid_gb) begin
          gb_cnt_d = gb_cnt_q + 1'b1;
        end else begin
          state_d = ST_CTRL;
        end
      end
      ST_DI_GB_LEAD: begin
        if (gb_cnt_q == GB_MAX) begin
          state_d = ST_ISLAND;
        end else if (isl_gb) begin
          gb_cnt_d = gb_cnt_q + 1'b1;
        end else begin
          state_d = ST_CTRL;
        end
      end
      ST_VIDEO: begin
        if (c0d[2]) state_d = ST_CTRL;
      end
      ST_ISLAND: begin
        if (c0d[2]) begin
          state_d      = ST_CTRL;
          isl_ctrl_err = 1'b1;
        end else if (isl_gb) begin
          state_d  = ST_DI_GB_TRAIL;
          gb_cnt_d = GW'(1);
        end
      end
      ST_DI_GB_TRAIL: begin
        if (c0d[2] || (gb_cnt_q == GB_MAX)) begin
          state_d = ST_CTRL;
        end else begin
          gb_cnt_d = gb_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_CTRL;
    endcase
  end

  logic                 hs_q, vs_q, hs_d, vs_d;
  logic [11:0]          idat_q, idat_d;
  logic                 ivld_q, ivld_d;
  logic                 vact_q;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] ecnt_q;

  // Each word is interpreted in the period it enters, matching period_state.
  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
    idat_d = idat_q;
    ivld_d = 1'b0;
    err_d  = isl_ctrl_err;
    case (state_d)
      ST_CTRL: begin
        if (c0d[2]) {vs_d, hs_d} = c0d[1:0];
      end
      ST_DI_GB_LEAD, ST_DI_GB_TRAIL: begin
        if (t0d[4]) {vs_d, hs_d} = t0d[1:0];
        else        err_d = 1'b1;
      end
      ST_ISLAND: begin
        if (t0d[4]) {vs_d, hs_d} = t0d[1:0];
        if (t0d[4] && t1d[4] && t2d[4]) begin
          ivld_d = 1'b1;
          idat_d = {t2d[3:0], t1d[3:0], t0d[3:0]};
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      idat_q <= '0;
      ivld_q <= 1'b0;
      vact_q <= 1'b0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      idat_q <= idat_d;
      ivld_q <= ivld_d;
      vact_q <= (state_d == ST_VIDEO);
      err_q  <= err_d;
      // Clear wins over a coincident error; the count sticks at all-ones.
      if (bus.clr_err_in)
        ecnt_q <= '0;
      else if (err_d && !(&ecnt_q))
        ecnt_q <= ecnt_q + 1'b1;
    end
  end

  assign bus.hsync_terc4  = hs_q;
  assign bus.vsync_terc4  = vs_q;
  assign bus.island_data  = idat_q;
  assign bus.island_valid = ivld_q;
  assign bus.video_active = vact_q;
  assign bus.period_state = state_q;
  assign bus.terc4_err    = err_q;
  assign bus.err_count    = ecnt_q;

endmodule

// File: tb/tb_hdmi_period_decoder.sv
// Directed bench for hdmi_period_decoder: expected outputs queued per word, checked one cycle later.
module tb_hdmi_period_decoder;

  localparam int EW = 3;

  localparam logic [9:0] CT00 = 10'b1101010100;
  localparam logic [9:0] CT01 = 10'b0010101011;
  localparam logic [9:0] CT10 = 10'b0101010100;
  localparam logic [9:0] CT11 = 10'b1010101011;
  localparam logic [9:0] GBO  = 10'b1011001100;
  localparam logic [9:0] GBM  = 10'b0100110011;
  localparam logic [9:0] PIX  = 10'b1111100000;
  localparam logic [9:0] BAD  = 10'b0000000000;
  localparam logic [9:0] TC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  typedef struct {
    string          tag;
    logic [2:0]     st;
    logic           va, hs, vs, iv, err;
    logic [11:0]    idat;
    logic [EW-1:0]  ecnt;
  } exp_t;

  logic clk_1x_in = 1'b0;
  logic rst_n_in  = 1'b1;

  hdmi_period_decoder_if #(.ERR_CNT_W(EW)) bus ();

  hdmi_period_decoder #(
    .PREAMBLE_LEN(8),
    .GUARD_LEN   (2),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk_1x_in(clk_1x_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_1x_in = ~clk_1x_in;

  int            n_pass = 0;
  int            n_chk  = 0;
  exp_t          sb[$];
  logic          eh = 1'b0, ev = 1'b0;
  logic [11:0]   ed = '0;
  logic [EW-1:0] ec = '0;

  function automatic logic [29:0] w3(input logic [9:0] c2, input logic [9:0] c1, input logic [9:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [2:0] st, input logic iv, input logic err);
    exp_t e;
    e.tag = tag; e.st = st; e.va = (st == 3'd2);
    e.hs = eh; e.vs = ev; e.iv = iv; e.err = err; e.idat = ed; e.ecnt = ec;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_chk++;
    assert (sb.size() != 0) n_pass++;
    else begin
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".period_state"}, 16'(bus.period_state), 16'(e.st));
    chk({e.tag, ".video_active"}, 16'(bus.video_active), 16'(e.va));
    chk({e.tag, ".hsync"},        16'(bus.hsync_terc4),  16'(e.hs));
    chk({e.tag, ".vsync"},        16'(bus.vsync_terc4),  16'(e.vs));
    chk({e.tag, ".island_valid"}, 16'(bus.island_valid), 16'(e.iv));
    chk({e.tag, ".island_data"},  16'(bus.island_data),  16'(e.idat));
    chk({e.tag, ".terc4_err"},    16'(bus.terc4_err),    16'(e.err));
    chk({e.tag, ".err_count"},    16'(bus.err_count),    16'(e.ecnt));
  endtask

  // Drive one word away from the active edge, queue its expectation, check after the edge.
  task automatic step(input string tag, input logic [29:0] w, input logic [2:0] st,
                      input logic iv, input logic err, input logic clr = 1'b0);
    @(negedge clk_1x_in);
    bus.deser_data = w;
    bus.clr_err_in = clr;
    if (clr)                    ec = '0;
    else if (err && (ec != '1)) ec = ec + 1'b1;
    push_exp(tag, st, iv, err);
    @(posedge clk_1x_in);
    #1;
    pop_check();
  endtask

  task automatic enter_island(input string tag);
    eh = 1'b1; ev = 1'b1;
    for (int i = 0; i < 8; i++) step({tag, ".pre"}, w3(CT01, CT01, CT11), 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step({tag, ".lead_gb"}, w3(GBM, GBM, TC[3]), 3'd3, 1'b0, 1'b0);
    ed = 12'h777;
    step({tag, ".d777"}, w3(TC[7], TC[7], TC[7]), 3'd4, 1'b1, 1'b0);
  endtask

  initial begin
    bus.deser_data = '0;
    bus.clr_err_in = 1'b0;
    #3 rst_n_in = 1'b0;
    #1;
    push_exp("reset", 3'd0, 1'b0, 1'b0);
    pop_check();
    repeat (2) @(posedge clk_1x_in);
    @(negedge clk_1x_in) rst_n_in = 1'b1;

    // Control tokens on ch0 drive hsync/vsync directly.
    eh = 1'b1; ev = 1'b0; step("ctrl01", w3(PIX, PIX, CT01), 3'd0, 1'b0, 1'b0);
    eh = 1'b0; ev = 1'b1; step("ctrl10", w3(PIX, PIX, CT10), 3'd0, 1'b0, 1'b0);

    // Short preamble, then a pattern change that restarts the count: neither arms.
    eh = 1'b1; ev = 1'b1;
    for (int i = 0; i < 7; i++) step("pre7", w3(CT00, CT01, CT11), 3'd0, 1'b0, 1'b0);
    step("pre7_gb", w3(GBO, GBM, GBO), 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("chg_a", w3(CT00, CT01, CT11), 3'd0, 1'b0, 1'b0);
    step("chg_b", w3(CT01, CT01, CT11), 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("chg_c", w3(CT00, CT01, CT11), 3'd0, 1'b0, 1'b0);
    step("chg_gb", w3(GBO, GBM, GBO), 3'd0, 1'b0, 1'b0);

    // Video period entry and exit.
    for (int i = 0; i < 8; i++) step("vpre", w3(CT00, CT01, CT11), 3'd0, 1'b0, 1'b0);
    step("vgb1", w3(GBO, GBM, GBO), 3'd1, 1'b0, 1'b0);
    step("vgb2", w3(GBO, GBM, GBO), 3'd1, 1'b0, 1'b0);
    step("pix1", w3(PIX, PIX, PIX), 3'd2, 1'b0, 1'b0);
    step("pix2", w3(PIX, PIX, PIX), 3'd2, 1'b0, 1'b0);
    eh = 1'b0; ev = 1'b0; step("vexit", w3(PIX, PIX, CT00), 3'd0, 1'b0, 1'b0);

    // Data island: payload, bad channel, trailing guard band.
    enter_island("isl1");
    eh = 1'b0; ev = 1'b1; ed = 12'h5A2;
    step("d5a2", w3(TC[5], TC[10], TC[2]), 3'd4, 1'b1, 1'b0);
    eh = 1'b0; ev = 1'b0;
    step("bad_ch1", w3(TC[0], BAD, TC[4]), 3'd4, 1'b0, 1'b1);
    eh = 1'b1; ev = 1'b0;
    step("tgb1", w3(GBM, GBM, TC[1]), 3'd5, 1'b0, 1'b0);
    step("tgb2", w3(GBM, GBM, TC[1]), 3'd5, 1'b0, 1'b0);
    step("tgb_done", w3(GBM, GBM, TC[1]), 3'd0, 1'b0, 1'b0);

    // Control token inside an island aborts with an error.
    enter_island("isl2");
    eh = 1'b0; ev = 1'b1;
    step("isl_ctrl", w3(PIX, PIX, CT10), 3'd0, 1'b0, 1'b1);

    // Error counter saturation and clear-over-error.
    enter_island("isl3");
    eh = 1'b0; ev = 1'b0;
    for (int i = 0; i < 6; i++) step("sat", w3(TC[0], BAD, TC[4]), 3'd4, 1'b0, 1'b1);
    step("clr_drop", w3(TC[0], BAD, TC[4]), 3'd4, 1'b0, 1'b1, 1'b1);
    step("after_clr", w3(TC[0], BAD, TC[4]), 3'd4, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an island.
    #2 rst_n_in = 1'b0;
    bus.deser_data = '0;
    eh = 1'b0; ev = 1'b0; ed = '0; ec = '0;
    #1;
    push_exp("mid_reset", 3'd0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk_1x_in) rst_n_in = 1'b1;
    eh = 1'b1; ev = 1'b0; step("post_reset", w3(PIX, PIX, CT01), 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
